// File: rtl/cache_block_streamer.sv
// Streams a burst of consecutive cache blocks out of a single-port RAM into a
// valid/ready channel, keeping at most two blocks buffered or in flight.
module cache_block_streamer #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int LG_DEPTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [LG_DEPTH-1:0] req_addr,
    input  logic [LG_DEPTH:0]   req_count,
    output logic                ram_en,
    output logic [LG_DEPTH-1:0] ram_addr,
    input  logic [WIDTH-1:0]    ram_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic                done
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [LG_DEPTH-1:0] addr_r;
    logic [LG_DEPTH:0]   remaining_r;
    logic                inflight_r;
    logic                inflight_last_r;
    logic [WIDTH-1:0]    fifo_data_r [2];
    logic                fifo_last_r [2];
    logic                rd_ptr_r;
    logic                wr_ptr_r;
    logic [1:0]          fifo_cnt_r;
    logic                done_r;

    logic                accept_s;
    logic                valid_s;
    logic [WIDTH-1:0]    head_data_s;
    logic                head_last_s;
    logic                pop_s;
    logic                fifo_pop_s;
    logic                push_s;
    logic [1:0]          total_s;
    logic                issue_s;

    // The returning read word acts as a virtual head entry while the FIFO is
    // empty, so the first block is visible the cycle its RAM data arrives.
    always_comb begin
        accept_s    = 1'b0;
        valid_s     = 1'b0;
        head_data_s = fifo_data_r[rd_ptr_r];
        head_last_s = fifo_last_r[rd_ptr_r];
        pop_s       = 1'b0;
        fifo_pop_s  = 1'b0;
        push_s      = 1'b0;
        total_s     = 2'd0;
        issue_s     = 1'b0;

        accept_s = (state_r == IDLE) && req_valid;
        valid_s  = (fifo_cnt_r != 2'd0) || inflight_r;
        if (fifo_cnt_r != 2'd0) begin
            head_data_s = fifo_data_r[rd_ptr_r];
            head_last_s = fifo_last_r[rd_ptr_r];
        end else if (inflight_r) begin
            head_data_s = ram_dout;
            head_last_s = inflight_last_r;
        end else begin
            head_data_s = fifo_data_r[rd_ptr_r];
            head_last_s = fifo_last_r[rd_ptr_r];
        end
        pop_s      = valid_s && out_ready;
        fifo_pop_s = pop_s && (fifo_cnt_r != 2'd0);
        push_s     = inflight_r && !(pop_s && (fifo_cnt_r == 2'd0));
        total_s    = fifo_cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
        issue_s    = (state_r == STREAM) && (remaining_r != (LG_DEPTH+1)'(0))
                     && (total_s < 2'd2);
    end

    // Next-state logic: leave STREAM only when the final beat is accepted.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (req_count != (LG_DEPTH+1)'(0))) begin
                    state_s = STREAM;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (pop_s && head_last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STREAM;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, burst counters, in-flight tracking and output FIFO storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            addr_r          <= '0;
            remaining_r     <= '0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            fifo_data_r[0]  <= '0;
            fifo_data_r[1]  <= '0;
            fifo_last_r[0]  <= 1'b0;
            fifo_last_r[1]  <= 1'b0;
            rd_ptr_r        <= 1'b0;
            wr_ptr_r        <= 1'b0;
            fifo_cnt_r      <= 2'd0;
            done_r          <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (accept_s && (req_count == (LG_DEPTH+1)'(0)))
                       || ((state_r == STREAM) && pop_s && head_last_s);
            if (accept_s) begin
                addr_r      <= req_addr;
                remaining_r <= req_count;
            end else if (issue_s) begin
                addr_r      <= addr_r + LG_DEPTH'(1);
                remaining_r <= remaining_r - (LG_DEPTH+1)'(1);
            end
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && (remaining_r == (LG_DEPTH+1)'(1));
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= ram_dout;
                fifo_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, fifo_pop_s};
        end
    end

    assign req_ready = (state_r == IDLE);
    assign ram_en    = issue_s;
    assign ram_addr  = addr_r;
    assign out_valid = valid_s;
    assign out_data  = head_data_s;
    assign out_last  = head_last_s;
    assign done      = done_r;

endmodule

// File: tb/tb_cache_block_streamer.sv
// Directed bench for cache_block_streamer: a queue scoreboard holds expected
// read addresses and output beats, and a negedge monitor pops and compares.
module tb_cache_block_streamer;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 64;
    localparam int LG_DEPTH = 6;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [LG_DEPTH-1:0] req_addr;
    logic [LG_DEPTH:0]   req_count;
    logic                ram_en;
    logic [LG_DEPTH-1:0] ram_addr;
    logic [WIDTH-1:0]    ram_dout = '0;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_last;
    logic                done;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [WIDTH:0]      exp_q [$];
    logic [LG_DEPTH-1:0] exp_addr_q [$];
    int                  checks = 0;
    int                  errors = 0;
    int                  en_cnt = 0;

    cache_block_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_count(req_count), .ram_en(ram_en),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
    end

    // Synchronous-read RAM: data appears the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for RAM reads and transferred beats.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ram_en === 1'b1) begin
                en_cnt++;
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_ram_en", 32'(ram_addr), 32'hFFFF);
                end else begin
                    chk("ram_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_data), 32'hFFFF);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e[WIDTH-1:0]));
                    chk("out_last", 32'(out_last), 32'(e[WIDTH]));
                end
            end
        end
    end

    task automatic push_exp(input int a, input int n, input int ndata);
        for (int i = 0; i < n; i++) exp_addr_q.push_back(LG_DEPTH'((a + i) % DEPTH));
        for (int i = 0; i < ndata; i++)
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, mem[(a + i) % DEPTH]});
    endtask

    task automatic drive_req(input int a, input int n);
        req_valid = 1'b1;
        req_addr  = LG_DEPTH'(a);
        req_count = (LG_DEPTH+1)'(n);
    endtask

    // Runs from posedge+1 of the cycle after acceptance until done is seen.
    task automatic wait_done(input int budget, input bit rnd);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("req_ready_at_done", 32'(req_ready), 32'd1);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic burst(input int a, input int n, input bit rnd);
        push_exp(a, n, n);
        drive_req(a, n);
        @(negedge clk);
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done(600, rnd);
    endtask

    initial begin
        int en0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_count = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Basic burst with cycle-exact timing
        push_exp(4, 3, 3);
        drive_req(4, 3);
        @(negedge clk);
        chk("s1_accept", 32'(req_ready), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("s1_ram_en_c%0d", k), 32'(ram_en), 32'((k <= 3) ? 1 : 0));
            chk($sformatf("s1_valid_c%0d", k), 32'(out_valid), 32'((k >= 2 && k <= 4) ? 1 : 0));
            chk($sformatf("s1_done_c%0d", k), 32'(done), 32'((k == 5) ? 1 : 0));
            chk($sformatf("s1_ready_c%0d", k), 32'(req_ready), 32'((k == 5) ? 1 : 0));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("s1_done_after", 32'(done), 32'd0);
        @(posedge clk); #1;

        // Wrap from the top of the RAM
        burst(62, 4, 1'b0);

        // Downstream stall for 10 cycles
        en0 = en_cnt;
        out_ready = 1'b0;
        push_exp(10, 5, 5);
        drive_req(10, 5);
        @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            if (k >= 2) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'(out_data), 32'd10);
            end
        end
        chk("stall_reads", 32'(en_cnt - en0), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(100, 1'b0);

        // Zero-length request
        en0 = en_cnt;
        drive_req(5, 0);
        @(negedge clk);
        chk("z_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("z_done", 32'(done), 32'd1);
        chk("z_valid", 32'(out_valid), 32'd0);
        chk("z_ready_next", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_done_off", 32'(done), 32'd0);
        chk("z_no_reads", 32'(en_cnt - en0), 32'd0);
        @(posedge clk); #1;

        // Reset after the second beat of a six-block burst
        push_exp(20, 6, 2);
        drive_req(20, 6);
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_addr_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("r_valid", 32'(out_valid), 32'd0);
            chk("r_ready", 32'(req_ready), 32'd1);
            chk("r_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        chk("r_beats", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        burst(0, 1, 1'b0);

        // Full-depth burst with random backpressure
        burst(0, DEPTH, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_block_streamer.md
CACHE_BLOCK_STREAMER -- requirements
Module: cache_block_streamer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: bit width of one cache block (one RAM word).
REQ-002 The module SHALL have parameter DEPTH, default 64: number of RAM words.
REQ-003 The module SHALL have parameter LG_DEPTH, default 6: address width, equal to log2(DEPTH).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port req_valid, input, 1 bit: burst request present.
REQ-007 The module SHALL have port req_ready, output, 1 bit: streamer can accept a request.
REQ-008 The module SHALL have port req_addr, input, LG_DEPTH bits: first block address.
REQ-009 The module SHALL have port req_count, input, LG_DEPTH+1 bits: number of blocks to stream, from 0 to DEPTH.
REQ-010 The module SHALL have port ram_en, output, 1 bit: read enable to one RAM port (write enable tied low externally).
REQ-011 The module SHALL have port ram_addr, output, LG_DEPTH bits: RAM read address.
REQ-012 The module SHALL have port ram_dout, input, WIDTH bits: RAM read data, valid exactly one cycle after ram_en.
REQ-013 The module SHALL have port out_valid, output, 1 bit: block available downstream.
REQ-014 The module SHALL have port out_ready, input, 1 bit: downstream accepts the block.
REQ-015 The module SHALL have port out_data, output, WIDTH bits: block data.
REQ-016 The module SHALL have port out_last, output, 1 bit: out_data is the final block of the burst.
REQ-017 The module SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-018 The streamer SHALL implement the states IDLE and STREAM; in IDLE, req_ready SHALL be 1, and in STREAM it SHALL be 0.
REQ-019 When req_valid and req_ready are both 1 in IDLE, the streamer SHALL latch req_addr as the next address and req_count as the remaining count.
- If req_count is nonzero, the state SHALL become STREAM.
- If req_count is 0, the state SHALL stay IDLE, no ram_en SHALL be issued, and done SHALL pulse on the next cycle.
REQ-020 The streamer SHALL hold a 2-entry output FIFO and track reads in flight (0 or 1).
- ram_en SHALL be 1 only in STREAM, when remaining > 0 and (FIFO occupancy + in-flight) < 2.
- The occupancy SHALL account for a same-cycle output pop.
REQ-021 On each ram_en, ram_addr SHALL equal the current address.
- The address SHALL then increment modulo DEPTH, so a burst wraps from DEPTH-1 to 0.
- remaining SHALL decrement by 1.
REQ-022 On the cycle after ram_en, ram_dout SHALL be pushed into the FIFO together with a last flag; the flag SHALL be 1 iff this was the burst's final read.
REQ-023 out_valid SHALL be 1 whenever the FIFO is non-empty; out_data and out_last SHALL come from the FIFO head.
- out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 A beat SHALL transfer when out_valid and out_ready are both 1; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-025 Latency and throughput:
- request accepted in cycle 0;
- first ram_en in cycle 1;
- first out_valid in cycle 2;
- with out_ready held at 1, one block SHALL be output per cycle with no bubbles.
REQ-026 When the beat with out_last=1 transfers, the state SHALL return to IDLE and done SHALL be 1 for exactly the next cycle; req_ready SHALL be 1 in that cycle.
REQ-027 A new request SHALL NOT be accepted in the same cycle as the last beat's transfer.
REQ-028 The FIFO SHALL never overflow; reads SHALL stall while (FIFO occupancy + in-flight) = 2.
REQ-029 req_count = DEPTH SHALL stream every RAM word exactly once, starting at req_addr.

Reset
REQ-030 When rst_n=0 at a clock edge, the streamer SHALL do the following:
- state SHALL become IDLE;
- the FIFO SHALL be emptied and in-flight, address and remaining SHALL be cleared;
- req_ready SHALL be 1, and ram_en, ram_addr, out_valid, out_data, out_last and done SHALL be 0.
REQ-031 A reset during STREAM SHALL abandon the burst.
- No done pulse SHALL be produced.
- ram_dout returning after reset SHALL be ignored.

Verification
REQ-032 The bench SHALL cover the following scenario: RAM preloaded with word i = i; request addr=4, count=3, out_ready=1.
- Required: ram_en in cycles 1-3 at addrs 4, 5, 6;
- out_data 4, 5, 6 in cycles 2-4;
- out_last only on 6;
- done in cycle 5.
REQ-033 The bench SHALL cover the following scenario: request addr=62, count=4 (DEPTH=64).
- Required: ram_addr sequence 62, 63, 0, 1 and output 62, 63, 0, 1.
REQ-034 The bench SHALL cover the following scenario: request count=5 with out_ready=0 for 10 cycles, then 1.
- Required: exactly 2 ram_en while stalled;
- out_data is held stable;
- all 5 blocks are delivered in order afterwards, with no loss or duplication.
REQ-035 The bench SHALL cover the following scenario: request count=0.
- Required: no ram_en, no out_valid, done pulse on the next cycle, req_ready stays 1.
REQ-036 The bench SHALL cover the following scenario: rst_n=0 asserted for one cycle after the 2nd beat of a count=6 burst.
- Required: out_valid=0 and req_ready=1 after reset, no done;
- a following request addr=0, count=1 returns word 0 with out_last=1.
REQ-037 The bench SHALL cover the following scenario: random out_ready with 50% duty over count=DEPTH.
- Required: all 64 words are received in address order, with out_last only on the 64th word.
